// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO-side arbiters.
// State encoding and width function used by the write arbiter and its picker.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for an argument of 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned w = value - 1; w > 0; w = w >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after last_ptr,
// wrapping modulo NUM_REQ, so last_ptr itself has the lowest priority.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_BITS = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] last_ptr,
    output logic [ID_BITS-1:0] pick,
    output logic               any
);

    logic [ID_BITS-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_BITS'((32'(last_ptr) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one syncFifo write port among
// NUM_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned ID_BITS   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           fifo_we,
    output logic [DATA_BITS-1:0]           fifo_dataIn,
    input  logic                           fifo_wfull,
    output logic                           grant_valid,
    output logic [ID_BITS-1:0]             grant_id,
    output logic                           busy
);

    localparam int unsigned CNT_BITS = clog2(MAX_BURST + 1);

    state_t               state;
    logic [ID_BITS-1:0]   last_ptr;
    logic [CNT_BITS-1:0]  beat_cnt;
    logic [ID_BITS-1:0]   pick;
    logic                 any;
    logic                 g_valid;
    logic                 burst_end;
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_pick (
        .req      (req_valid),
        .last_ptr (last_ptr),
        .pick     (pick),
        .any      (any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign g_valid     = req_valid[grant_id];
    assign burst_end   = req_last[grant_id] || (beat_cnt == CNT_BITS'(MAX_BURST - 1));
    assign fifo_dataIn = data_arr[grant_id];
    assign busy        = (|req_valid) | grant_valid;

    // Handshake is combinational so the FIFO write lands in the accept cycle.
    always_comb begin
        req_ready = '0;
        fifo_we   = 1'b0;
        if (state == ST_GRANT) begin
            req_ready[grant_id] = ~fifo_wfull;
            fifo_we             = g_valid & ~fifo_wfull;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_ptr    <= ID_BITS'(NUM_REQ - 1);
            beat_cnt    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        grant_id    <= pick;
                        last_ptr    <= pick;
                        beat_cnt    <= '0;
                        state       <= ST_GRANT;
                        grant_valid <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!g_valid) begin
                        state       <= ST_IDLE;
                        grant_valid <= 1'b0;
                    end else if (fifo_we) begin
                        if (burst_end) begin
                            state       <= ST_IDLE;
                            grant_valid <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_BITS'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 producers, 8-bit data, bursts of 8).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_we;
    logic [7:0]  fifo_dataIn;
    logic        fifo_wfull;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_BITS (8),
        .MAX_BURST (8),
        .ID_BITS   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_we     (fifo_we),
        .fifo_dataIn (fifo_dataIn),
        .fifo_wfull  (fifo_wfull),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance past the next edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l, input logic wf,
                       input logic egv, input logic [1:0] eid, input logic ewe,
                       input logic [3:0] erdy, input logic [7:0] edata);
        req_valid  = v;
        req_last   = l;
        fifo_wfull = wf;
        #1;
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(egv));
        chk({tag, ".grant_id"},    32'(grant_id),    32'(eid));
        chk({tag, ".fifo_we"},     32'(fifo_we),     32'(ewe));
        chk({tag, ".req_ready"},   32'(req_ready),   32'(erdy));
        chk({tag, ".busy"},        32'(busy),        32'((|v) | egv));
        if (ewe) chk({tag, ".data"}, 32'(fifo_dataIn), 32'(edata));
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        fifo_wfull = 1'b0;

        @(posedge clk);
        #2;
        chk("rst.grant_valid", 32'(grant_valid), 32'd0);
        chk("rst.fifo_we",     32'(fifo_we),     32'd0);
        chk("rst.req_ready",   32'(req_ready),   32'd0);
        chk("rst.grant_id",    32'(grant_id),    32'd0);
        chk("rst.busy",        32'(busy),        32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // T1: producers 1 and 2 stream without last; MAX_BURST splits them.
        cyc("t1.arb", 4'b0110, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 8; i++) cyc("t1.p1", 4'b0110, 4'b0000, 0, 1, 2'd1, 1, 4'b0010, 8'hD1);
        cyc("t1.gap1", 4'b0110, 4'b0000, 0, 0, 2'd1, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 8; i++) cyc("t1.p2", 4'b0110, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 8'hD2);
        cyc("t1.gap2", 4'b0110, 4'b0000, 0, 0, 2'd2, 0, 4'b0000, 8'h00);
        cyc("t1.p1b", 4'b0110, 4'b0000, 0, 1, 2'd1, 1, 4'b0010, 8'hD1);
        cyc("t1.drop", 4'b0000, 4'b0000, 0, 1, 2'd1, 0, 4'b0010, 8'h00);
        cyc("t1.idle", 4'b0000, 4'b0000, 0, 0, 2'd1, 0, 4'b0000, 8'h00);

        // T2: producer 3 alone, three beats ending in last.
        req_data[31:24] = 8'hA1;
        cyc("t2.arb", 4'b1000, 4'b0000, 0, 0, 2'd1, 0, 4'b0000, 8'h00);
        cyc("t2.b1",  4'b1000, 4'b0000, 0, 1, 2'd3, 1, 4'b1000, 8'hA1);
        req_data[31:24] = 8'hA2;
        cyc("t2.b2",  4'b1000, 4'b0000, 0, 1, 2'd3, 1, 4'b1000, 8'hA2);
        req_data[31:24] = 8'hA3;
        cyc("t2.b3",  4'b1000, 4'b1000, 0, 1, 2'd3, 1, 4'b1000, 8'hA3);
        req_data[31:24] = 8'hD3;
        cyc("t2.gap", 4'b0000, 4'b0000, 0, 0, 2'd3, 0, 4'b0000, 8'h00);

        // T3: producer 0 stalled by wfull for 5 cycles mid-burst.
        cyc("t3.arb", 4'b0001, 4'b0000, 0, 0, 2'd3, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 3; i++) cyc("t3.pre",  4'b0001, 4'b0000, 0, 1, 2'd0, 1, 4'b0001, 8'hD0);
        for (int i = 0; i < 5; i++) cyc("t3.full", 4'b0001, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 5; i++) cyc("t3.post", 4'b0001, 4'b0000, 0, 1, 2'd0, 1, 4'b0001, 8'hD0);
        cyc("t3.gap",  4'b0001, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);
        cyc("t3.drop", 4'b0000, 4'b0000, 0, 1, 2'd0, 0, 4'b0001, 8'h00);
        cyc("t3.idle", 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);

        // T4: producer 2 abandons after two beats; 3 then 0 follow.
        cyc("t4.arb",  4'b1101, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);
        cyc("t4.p2a",  4'b1101, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 8'hD2);
        cyc("t4.p2b",  4'b1101, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 8'hD2);
        cyc("t4.drop", 4'b1001, 4'b0000, 0, 1, 2'd2, 0, 4'b0100, 8'h00);
        cyc("t4.gap1", 4'b1001, 4'b0000, 0, 0, 2'd2, 0, 4'b0000, 8'h00);
        cyc("t4.p3a",  4'b1001, 4'b0000, 0, 1, 2'd3, 1, 4'b1000, 8'hD3);
        cyc("t4.p3b",  4'b1001, 4'b1000, 0, 1, 2'd3, 1, 4'b1000, 8'hD3);
        cyc("t4.gap2", 4'b0001, 4'b0000, 0, 0, 2'd3, 0, 4'b0000, 8'h00);
        cyc("t4.p0a",  4'b0001, 4'b0000, 0, 1, 2'd0, 1, 4'b0001, 8'hD0);
        cyc("t4.p0b",  4'b0001, 4'b0001, 0, 1, 2'd0, 1, 4'b0001, 8'hD0);

        // T5: async reset during producer 1's burst.
        cyc("t5.arb",  4'b0010, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);
        cyc("t5.p1a",  4'b0010, 4'b0000, 0, 1, 2'd1, 1, 4'b0010, 8'hD1);
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        #1;
        chk("t5.pre.grant_valid", 32'(grant_valid), 32'd1);
        chk("t5.pre.fifo_we",     32'(fifo_we),     32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5.rst.grant_valid", 32'(grant_valid), 32'd0);
        chk("t5.rst.fifo_we",     32'(fifo_we),     32'd0);
        chk("t5.rst.req_ready",   32'(req_ready),   32'd0);
        chk("t5.rst.grant_id",    32'(grant_id),    32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // T6: everyone valid, two-beat bursts; strict 0,1,2,3 rotation.
        cyc("t6.arb", 4'b1111, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cyc("t6.b1",  4'b1111, 4'b0000, 0, 1, 2'(k % 4), 1, 4'(1 << (k % 4)), 8'(8'hD0 + k % 4));
            cyc("t6.b2",  4'b1111, 4'b1111, 0, 1, 2'(k % 4), 1, 4'(1 << (k % 4)), 8'(8'hD0 + k % 4));
            cyc("t6.gap", 4'b1111, 4'b0000, 0, 0, 2'(k % 4), 0, 4'b0000, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
